// File: rtl/key_debounce_encoder_if.sv
// Bundle of switch inputs and note outputs exchanged between the key input stage and its consumers.
// The master side drives the raw switches; the slave side (the encoder) drives the note outputs.
interface key_debounce_encoder_if #(
  parameter int NUM_KEYS = 5
);
  logic [NUM_KEYS-1:0] switch;
  logic [2:0]          note_code;
  logic                note_on;
  logic                note_strobe;
  logic [NUM_KEYS-1:0] key_stable;

  modport master (
    output switch,
    input  note_code, note_on, note_strobe, key_stable
  );

  modport slave (
    input  switch,
    output note_code, note_on, note_strobe, key_stable
  );
endinterface

// File: rtl/key_debounce_encoder.sv
// Synchronise, debounce and priority-encode the note switches into a registered note code and strobe.
// Optional macro KEY_LAST_PRESS_EN selects last-pressed priority instead of lowest-index priority.
module key_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_KEYS        = 5
) (
  input logic                   clk,
  input logic                   rst,
  key_debounce_encoder_if.slave bus
);
  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync2_q;
  logic [NUM_KEYS-1:0] stable_q, stable_d;
  logic [2:0]          note_code_q, note_code_d;
  logic                note_strobe_q;

  function automatic logic [2:0] lowest_code(input logic [NUM_KEYS-1:0] v);
    lowest_code = 3'd0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_code = 3'(i + 1);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= bus.switch;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_nx;

    // Any cycle where the synchronised level agrees with the stable level restarts the count.
    always_comb begin
      cnt_d     = '0;
      stable_nx = stable_q[gi];
      if (sync2_q[gi] != stable_q[gi]) begin
        if (cnt_q == CNT_LAST) begin
          stable_nx = sync2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    assign stable_d[gi] = stable_nx;

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

`ifdef KEY_LAST_PRESS_EN
  logic [2:0]          last_key_q, last_key_d;
  logic [NUM_KEYS-1:0] rise;
  logic                last_held_q, last_held_d;

  // last_key tracks the newest press; it falls back to the lowest held key when that key lets go.
  always_comb begin
    rise        = stable_d & ~stable_q;
    last_held_q = 1'b0;
    last_held_d = 1'b0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (last_key_q == 3'(i + 1)) begin
        last_held_q = stable_q[i];
        last_held_d = stable_d[i];
      end
    end
    last_key_d = last_key_q;
    if (|rise) begin
      last_key_d = lowest_code(rise);
    end else if (last_key_q != 3'd0 && !last_held_d) begin
      last_key_d = lowest_code(stable_d);
    end
    note_code_d = (last_key_q != 3'd0 && last_held_q) ? last_key_q : lowest_code(stable_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_key_q <= 3'd0;
    end else begin
      last_key_q <= last_key_d;
    end
  end
`else
  always_comb begin
    note_code_d = lowest_code(stable_q);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      note_code_q   <= 3'd0;
      note_strobe_q <= 1'b0;
    end else begin
      note_code_q   <= note_code_d;
      note_strobe_q <= (note_code_d != note_code_q);
    end
  end

  assign bus.note_code   = note_code_q;
  assign bus.note_on     = (note_code_q != 3'd0);
  assign bus.note_strobe = note_strobe_q;
  assign bus.key_stable  = stable_q;
endmodule

// File: doc/key_debounce_encoder.md
# key_debounce_encoder

Input stage that sits directly upstream of the piano tone/display block. It synchronises and debounces the five note switches and resolves simultaneous presses to a single active note. It presents a registered note code, a note-on level and a one-cycle change strobe. The tone generator and seven-segment driver consume these outputs instead of the raw switches.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive cycles a synchronised switch must differ from its stable value before the change is accepted (10 ms at 100 MHz); legal range ≥1
- NUM_KEYS, 5, number of switch inputs; key i maps to note code i+1 (C, D, E, F, G)

- clk  input  1  system clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- switch  input  NUM_KEYS  raw asynchronous switch levels, 1 = pressed
- note_code  output  3  active note: 0 = none, i+1 = key i
- note_on  output  1  high when note_code ≠ 0
- note_strobe  output  1  one-cycle pulse in the cycle note_code takes a new value
- key_stable  output  NUM_KEYS  debounced switch levels

## Operation
- Per key: two-flop synchroniser (sync1, sync2), stable bit, counter of width $clog2(DEBOUNCE_CYCLES+1).
- Counter rule, each edge:
  - If sync2 == stable: cnt ← 0.
  - Else, if cnt == DEBOUNCE_CYCLES−1: stable ← sync2, cnt ← 0.
  - Else: cnt ← cnt+1.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles clears the counter and never changes stable.
- Selection (default): note_code_next = 1 + lowest index i with stable[i] = 1, else 0.
- Output register: note_code ← note_code_next every edge.
- note_strobe ← (note_code_next ≠ note_code).
- note_on is combinational from the registered note_code.
- Key transitions with no effect on the selected note produce no strobe. Example: pressing key 3 while key 0 is held.
- Reset clears sync1, sync2, stable, cnt, note_code, note_strobe and the last-key register. Reset outputs: note_code = 0, note_on = 0, note_strobe = 0, key_stable = 0.
- Reset asserted mid-count discards the partial count.
- After reset, a switch already held reports only after a full debounce period.

## Timing
- Switch change first sampled at edge k: sync2 updates at k+1, stable at k+1+DEBOUNCE_CYCLES, note_code and note_strobe at k+2+DEBOUNCE_CYCLES.
- Release follows the same latency as press.
- Simultaneous stable changes on several keys in one cycle resolve in that same cycle; at most one strobe results.
- note_strobe is never high in two consecutive cycles unless note_code changes on both edges.
- No handshake: downstream samples every cycle.
- No counter wrap: cnt never exceeds DEBOUNCE_CYCLES−1.

## Configuration
- KEY_LAST_PRESS_EN defined: last-pressed priority.
  - A last_key register (3 bits, 0 = none) is loaded with i+1 on each stable rising edge of key i.
  - If several keys rise in the same cycle, the lowest index among them is loaded.
  - While stable[last_key−1] = 1, note_code_next = last_key.
  - When that key releases, selection falls back to the lowest-index held key, and last_key is loaded with that key's code.
- Undefined: lowest-index priority only; no last_key register is built.

## Test plan
- DEBOUNCE_CYCLES = 4, switch = 00001 held, first sampled at edge 10 -> note_code = 1, note_on = 1, note_strobe = 1 exactly at edge 16; note_code = 0 with one strobe 6 edges after release.
- switch = 00010 pulsed for 3 cycles then 0 -> note_code stays 0, key_stable stays 0, no strobe.
- switch 00100 stable, then 00101 -> default build: note_code goes 3 → 1 with one strobe. KEY_LAST_PRESS_EN build: goes 3 → 1; releasing key 0 returns to 3, with strobe on each change.
- switch 00110 applied in one cycle -> note_code = 2 after the debounce period in both builds; one strobe.
- rst asserted for 1 cycle while key 4 is mid-count (cnt = 2) -> all outputs 0 next edge; note_code = 5 only after a fresh 4-cycle count.
- Key 0 held, key 3 pressed and released -> note_code remains 1 and no strobe (default build).
